// File: rtl/uart_frame_rx_pkg.sv
// Shared definitions for the multi-byte UART frame receiver: baud derivation,
// byte-receiver state encoding and frame geometry common with the transmitter.
package uart_frame_rx_pkg;

  localparam int FRAME_W          = 816;
  localparam int MAX_BYTES        = FRAME_W / 8;
  localparam int TIMEOUT_BITS_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  function automatic int baud_cnt_max(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

  // Zero-length frames degrade to one byte; oversize requests saturate at the buffer size.
  function automatic logic [7:0] clamp_digits(input logic [7:0] d);
    if (d == 8'd0) begin
      return 8'd1;
    end else if (d > 8'(MAX_BYTES)) begin
      return 8'(MAX_BYTES);
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: rx synchroniser, start/data/stop FSM with mid-bit sampling.
// Strobes are combinational so the frame layer can register them in the sample cycle.
module uart_byte_rx
  import uart_frame_rx_pkg::*;
#(
  parameter int BAUD_CNT_MAX = 1073,
  parameter int BAUD_HALF    = 536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       en,
  output logic       start_det,
  output logic       rx_idle,
  output logic [7:0] byte_data,
  output logic       byte_vld,
  output logic       byte_err,
  output logic       false_start
);

  localparam logic [15:0] HALF_C = 16'(BAUD_HALF);
  localparam logic [15:0] LAST_C = 16'(BAUD_CNT_MAX - 1);

  logic        rx_meta_r, rx_d1_r, rx_d2_r;
  rx_state_t   state_r, state_nx_s;
  logic [15:0] baud_cnt_r, baud_nx_s;
  logic [2:0]  bit_idx_r, bit_nx_s;
  logic [7:0]  shift_r, shift_nx_s;
  logic        mid_s, end_s;
  logic        start_s, vld_s, err_s, fstart_s;

  // rx synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_d1_r   <= 1'b1;
      rx_d2_r   <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_d1_r   <= rx_meta_r;
      rx_d2_r   <= rx_d1_r;
    end
  end

  // FSM and counter state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= 16'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'd0;
    end else begin
      state_r    <= state_nx_s;
      baud_cnt_r <= baud_nx_s;
      bit_idx_r  <= bit_nx_s;
      shift_r    <= shift_nx_s;
    end
  end

  assign mid_s = (baud_cnt_r == HALF_C);
  assign end_s = (baud_cnt_r == LAST_C);

  // Next-state, counters and strobes
  always_comb begin
    state_nx_s = state_r;
    baud_nx_s  = baud_cnt_r;
    bit_nx_s   = bit_idx_r;
    shift_nx_s = shift_r;
    start_s    = 1'b0;
    vld_s      = 1'b0;
    err_s      = 1'b0;
    fstart_s   = 1'b0;
    if (!en) begin
      state_nx_s = ST_IDLE;
      baud_nx_s  = 16'd0;
      bit_nx_s   = 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          baud_nx_s = 16'd0;
          bit_nx_s  = 3'd0;
          if (rx_d2_r && !rx_d1_r) begin
            start_s    = 1'b1;
            state_nx_s = ST_START;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_START: begin
          baud_nx_s = end_s ? 16'd0 : baud_cnt_r + 16'd1;
          if (mid_s && rx_d1_r) begin
            fstart_s   = 1'b1;
            state_nx_s = ST_IDLE;
            baud_nx_s  = 16'd0;
          end else if (end_s) begin
            state_nx_s = ST_DATA;
          end else begin
            state_nx_s = ST_START;
          end
        end
        ST_DATA: begin
          baud_nx_s = end_s ? 16'd0 : baud_cnt_r + 16'd1;
          if (mid_s) begin
            shift_nx_s = {rx_d1_r, shift_r[7:1]};
          end else begin
            shift_nx_s = shift_r;
          end
          if (end_s && (bit_idx_r == 3'd7)) begin
            bit_nx_s   = 3'd0;
            state_nx_s = ST_STOP;
          end else if (end_s) begin
            bit_nx_s = bit_idx_r + 3'd1;
          end else begin
            bit_nx_s = bit_idx_r;
          end
        end
        ST_STOP: begin
          // Leave at mid-stop so a start bit that follows immediately is still seen.
          if (mid_s) begin
            vld_s      = rx_d1_r;
            err_s      = !rx_d1_r;
            state_nx_s = ST_IDLE;
            baud_nx_s  = 16'd0;
          end else begin
            baud_nx_s = baud_cnt_r + 16'd1;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
          baud_nx_s  = 16'd0;
          bit_nx_s   = 3'd0;
        end
      endcase
    end
  end

  assign start_det   = start_s;
  assign rx_idle     = (state_r == ST_IDLE);
  assign byte_data   = shift_r;
  assign byte_vld    = vld_s;
  assign byte_err    = err_s;
  assign false_start = fstart_s;

endmodule

// File: rtl/uart_frame_rx.sv
// Multi-byte UART frame receiver: collects DIGIT_CNT bytes into an 816-bit word,
// first byte in the most significant used slot, with framing/timeout error reporting.
module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter int UART_BPS     = 89467,
  parameter int CLK_FREQ     = 96_000_000,
  parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               rx,
  input  logic               en,
  input  logic [7:0]         DIGIT_CNT,
  output logic [FRAME_W-1:0] po_data,
  output logic               po_flag,
  output logic               err_flag
);

  localparam int          BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int          BAUD_HALF    = BAUD_CNT_MAX / 2;
  localparam logic [31:0] TIMEOUT_LIM  = 32'(TIMEOUT_BITS * BAUD_CNT_MAX);

  logic               start_det_s, rx_idle_s, byte_vld_s, byte_err_s, false_start_s;
  logic [7:0]         byte_data_s;
  logic [7:0]         n_r, byte_cnt_r, slot_s;
  logic [31:0]        idle_cnt_r;
  logic [FRAME_W-1:0] frame_buf_r, frame_wr_s, po_data_r;
  logic               po_flag_r, err_flag_r;
  logic               last_byte_s, idle_run_s, timeout_s;

  uart_byte_rx #(
    .BAUD_CNT_MAX(BAUD_CNT_MAX),
    .BAUD_HALF   (BAUD_HALF)
  ) u_byte_rx (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .rx         (rx),
    .en         (en),
    .start_det  (start_det_s),
    .rx_idle    (rx_idle_s),
    .byte_data  (byte_data_s),
    .byte_vld   (byte_vld_s),
    .byte_err   (byte_err_s),
    .false_start(false_start_s)
  );

  // Frame buffer with the arriving byte merged into slot N-1-k
  always_comb begin
    frame_wr_s = frame_buf_r;
    slot_s     = n_r - 8'd1 - byte_cnt_r;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (slot_s == 8'(k)) begin
        frame_wr_s[k*8 +: 8] = byte_data_s;
      end else begin
        frame_wr_s[k*8 +: 8] = frame_buf_r[k*8 +: 8];
      end
    end
  end

  assign last_byte_s = (byte_cnt_r == n_r - 8'd1);
  assign idle_run_s  = rx_idle_s && (byte_cnt_r != 8'd0) && !start_det_s;
  assign timeout_s   = idle_run_s && (idle_cnt_r == TIMEOUT_LIM);

  // Inter-byte idle timer, only runs while a partial frame is pending
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      idle_cnt_r <= 32'd0;
    end else if (!en || !idle_run_s || timeout_s) begin
      idle_cnt_r <= 32'd0;
    end else begin
      idle_cnt_r <= idle_cnt_r + 32'd1;
    end
  end

  // Frame assembly, output word and status pulses
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      n_r         <= 8'd1;
      byte_cnt_r  <= 8'd0;
      frame_buf_r <= '0;
      po_data_r   <= '0;
      po_flag_r   <= 1'b0;
      err_flag_r  <= 1'b0;
    end else if (!en) begin
      byte_cnt_r  <= 8'd0;
      frame_buf_r <= '0;
      po_flag_r   <= 1'b0;
      err_flag_r  <= 1'b0;
    end else begin
      po_flag_r  <= 1'b0;
      err_flag_r <= 1'b0;
      if (start_det_s && (byte_cnt_r == 8'd0)) begin
        n_r <= clamp_digits(DIGIT_CNT);
      end else begin
        n_r <= n_r;
      end
      if (byte_vld_s && last_byte_s) begin
        po_data_r   <= frame_wr_s;
        po_flag_r   <= 1'b1;
        byte_cnt_r  <= 8'd0;
        frame_buf_r <= '0;
      end else if (byte_vld_s) begin
        byte_cnt_r  <= byte_cnt_r + 8'd1;
        frame_buf_r <= frame_wr_s;
      end else if (byte_err_s || timeout_s) begin
        err_flag_r  <= 1'b1;
        byte_cnt_r  <= 8'd0;
        frame_buf_r <= '0;
      end else if (false_start_s) begin
        err_flag_r <= 1'b1;
      end else begin
        byte_cnt_r <= byte_cnt_r;
      end
    end
  end

  assign po_data  = po_data_r;
  assign po_flag  = po_flag_r;
  assign err_flag = err_flag_r;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx at a reduced clock/baud ratio (16 clocks per bit)
// so the back-to-back 102-byte frame stays short; frames are table-driven.
module tb_uart_frame_rx;

  localparam int BIT = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx = 1'b1;
  logic         en = 1'b1;
  logic [7:0]   digit_cnt = 8'd1;
  logic [815:0] po_data;
  logic         po_flag, err_flag;

  int n_cmp = 0;
  int n_bad = 0;
  int flag_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int f0, e0;
  logic [815:0] prev_po, exp_po;
  logic [63:0]  tx_word;

  typedef struct {
    logic [7:0]  n;
    int          len;
    logic [7:0]  b [4];
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [5];

  uart_frame_rx #(
    .UART_BPS    (100_000),
    .CLK_FREQ    (1_600_000),
    .TIMEOUT_BITS(20)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .rx       (rx),
    .en       (en),
    .DIGIT_CNT(digit_cnt),
    .po_data  (po_data),
    .po_flag  (po_flag),
    .err_flag (err_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (po_flag) flag_cnt <= flag_cnt + 1;
    if (err_flag) err_cnt <= err_cnt + 1;
    if (po_flag && err_flag) both_cnt <= both_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(BIT);
    end
    rx = stop;
    idle(BIT);
    rx = 1'b1;
  endtask

  task automatic check(input string name, input logic [815:0] act, input logic [815:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0].n = 8'd3; vecs[0].len = 3; vecs[0].b = '{8'hA5, 8'h3C, 8'hFF, 8'h00}; vecs[0].exp = 32'h00A53CFF;
    vecs[1].n = 8'd1; vecs[1].len = 1; vecs[1].b = '{8'h5A, 8'h00, 8'h00, 8'h00}; vecs[1].exp = 32'h0000005A;
    vecs[2].n = 8'd0; vecs[2].len = 1; vecs[2].b = '{8'h81, 8'h00, 8'h00, 8'h00}; vecs[2].exp = 32'h00000081;
    vecs[3].n = 8'd4; vecs[3].len = 4; vecs[3].b = '{8'h01, 8'h02, 8'h03, 8'h04}; vecs[3].exp = 32'h01020304;
    vecs[4].n = 8'd2; vecs[4].len = 2; vecs[4].b = '{8'h00, 8'hFF, 8'h00, 8'h00}; vecs[4].exp = 32'h000000FF;

    idle(5);
    rst_n = 1'b1;
    idle(2);
    check("reset_po_data", po_data, 816'd0);
    check("reset_po_flag", {815'd0, po_flag}, 816'd0);
    check("reset_err_flag", {815'd0, err_flag}, 816'd0);

    // Table of single frames
    for (int i = 0; i < 5; i++) begin
      digit_cnt = vecs[i].n;
      f0 = flag_cnt; e0 = err_cnt;
      for (int j = 0; j < vecs[i].len; j++) send_byte(vecs[i].b[j], 1'b1);
      idle(4);
      check($sformatf("tbl%0d_po_data", i), po_data, {784'd0, vecs[i].exp});
      check($sformatf("tbl%0d_flags", i), 816'(flag_cnt - f0), 816'd1);
      check($sformatf("tbl%0d_errs", i), 816'(err_cnt - e0), 816'd0);
    end

    // Back-to-back 102 bytes, requested count oversize (clamped to 102)
    digit_cnt = 8'd200;
    f0 = flag_cnt; e0 = err_cnt;
    exp_po = '0;
    for (int k = 0; k < 102; k++) begin
      send_byte(8'(k), 1'b1);
      exp_po[(101-k)*8 +: 8] = 8'(k);
    end
    idle(4);
    check("b2b_po_data", po_data, exp_po);
    check("b2b_flags", 816'(flag_cnt - f0), 816'd1);
    check("b2b_errs", 816'(err_cnt - e0), 816'd0);

    // Framing error: stop bit low
    digit_cnt = 8'd1;
    prev_po = po_data;
    f0 = flag_cnt; e0 = err_cnt;
    send_byte(8'h55, 1'b0);
    idle(BIT);
    check("frm_err_errs", 816'(err_cnt - e0), 816'd1);
    check("frm_err_flags", 816'(flag_cnt - f0), 816'd0);
    check("frm_err_po_hold", po_data, prev_po);

    // Glitch shorter than half a bit, then a 2-byte frame must need both bytes
    digit_cnt = 8'd2;
    f0 = flag_cnt; e0 = err_cnt;
    rx = 1'b0; idle(4); rx = 1'b1; idle(2 * BIT);
    check("glitch_errs", 816'(err_cnt - e0), 816'd1);
    send_byte(8'h12, 1'b1);
    idle(4);
    check("glitch_no_early_flag", 816'(flag_cnt - f0), 816'd0);
    send_byte(8'h34, 1'b1);
    idle(4);
    check("glitch_frame_po", po_data, {800'd0, 16'h1234});

    // Timeout after 2 of 4 bytes, then a clean 4-byte frame
    digit_cnt = 8'd4;
    f0 = flag_cnt; e0 = err_cnt;
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    idle(21 * BIT);
    check("timeout_errs", 816'(err_cnt - e0), 816'd1);
    check("timeout_flags", 816'(flag_cnt - f0), 816'd0);
    f0 = flag_cnt; e0 = err_cnt;
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    idle(4);
    check("post_timeout_po", po_data, {784'd0, 32'h11223344});
    check("post_timeout_errs", 816'(err_cnt - e0), 816'd0);

    // en dropped mid byte 2 of 4; partial frame must be forgotten silently
    f0 = flag_cnt; e0 = err_cnt;
    send_byte(8'h99, 1'b1);
    rx = 1'b0; idle(BIT);
    rx = 1'b1; idle(BIT);
    rx = 1'b0; idle(BIT + BIT / 2);
    en = 1'b0; rx = 1'b1; idle(20);
    en = 1'b1; idle(20);
    check("abort_no_flags", 816'(flag_cnt - f0 + err_cnt - e0), 816'd0);
    send_byte(8'hC1, 1'b1); send_byte(8'hC2, 1'b1);
    send_byte(8'hC3, 1'b1); send_byte(8'hC4, 1'b1);
    idle(4);
    check("post_abort_po", po_data, {784'd0, 32'hC1C2C3C4});

    // Reset in the middle of a frame
    f0 = flag_cnt;
    send_byte(8'hAA, 1'b1);
    rx = 1'b0; idle(3 * BIT);
    rx = 1'b1;
    rst_n = 1'b0; idle(3);
    rst_n = 1'b1; idle(3);
    check("rst_mid_po_data", po_data, 816'd0);
    check("rst_mid_flags", {814'd0, po_flag, err_flag}, 816'd0);
    check("rst_mid_no_pulse", 816'(flag_cnt - f0), 816'd0);

    // Loopback-style 8-byte frame: bytes leave highest slot first
    digit_cnt = 8'd8;
    tx_word = 64'h0123_4567_89AB_CDEF;
    f0 = flag_cnt;
    for (int k = 7; k >= 0; k--) send_byte(tx_word[k*8 +: 8], 1'b1);
    idle(4);
    check("loopback_po", po_data, {752'd0, tx_word});
    check("loopback_flags", 816'(flag_cnt - f0), 816'd1);

    check("flags_never_together", 816'(both_cnt), 816'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
